axi_id_fold_serializer: RTL and testbench
=========================================

// Module: axi_id_fold_serializer
// PURPOSE
// - Successor of the single-ID serializer: folds a SlvIdWidth ID space onto 2**MstIdWidth downstream IDs
//   instead of one, keeping per-folded-ID ordering and parallelism across folded IDs.
// - Downstream ID = upstream ID[MstIdWidth-1:0]. Per-folded-ID FIFOs hold the full upstream ID for restoring R/B.
// - ATOPs are fully serialised (global drain). Sits in front of slaves/converters with narrow ID support.
// PARAMETERS
// - MaxReadTxns   4       max outstanding reads per downstream ID (read FIFO depth, >=1)
// - MaxWriteTxns  4       max outstanding writes per downstream ID (write FIFO depth, >=1)
// - SlvIdWidth    4       upstream AXI ID width (>= MstIdWidth)
// - MstIdWidth    2       downstream AXI ID width (>=1); NumMstIds = 2**MstIdWidth
// - slv_req_t     logic   AXI4+ATOP request type, upstream port (SlvIdWidth IDs)
// - slv_resp_t    logic   AXI4+ATOP response type, upstream port
// - mst_req_t     logic   AXI4+ATOP request type, downstream port (MstIdWidth IDs)
// - mst_resp_t    logic   AXI4+ATOP response type, downstream port
// PORTS
// - clk_i       in   1           clock, single domain
// - rst_ni      in   1           reset, asynchronous, active-low
// - slv_req_i   in   slv_req_t   upstream request
// - slv_resp_o  out  slv_resp_t  upstream response
// - mst_req_o   out  mst_req_t   downstream request
// - mst_resp_i  in   mst_resp_t  downstream response
// BEHAVIOUR
// - Purely combinational datapath, zero added latency. State: FSM, 2*NumMstIds ID FIFOs (non-fall-through),
//   counters rd_cnt and wr_cnt of total outstanding reads and writes.
// - Reset: state Idle, all FIFOs empty, counters 0.
//   Hence slv b_valid/r_valid = 0 and mst b_ready/r_ready = 0. AR/AW valid follow upstream, gated as below.
// - All fields pass through except: mst aw.id/ar.id = slv id[MstIdWidth-1:0].
//   slv b.id/r.id = head of write/read FIFO indexed by mst b.id/r.id. W passes through untouched.
// - AR (Idle only):
//   - mst ar_valid = slv ar_valid & ~rd_full[k], with k = folded ID; slv ar_ready = mst ar_ready & ~rd_full[k].
//   - Handshake pushes the full upstream ID into rd_fifo[k] and increments rd_cnt.
// - AW non-ATOP (Idle only): same gating with wr_full[k]; handshake pushes wr_fifo[k] and increments wr_cnt.
//   AR and AW may both handshake in one cycle.
// - B: slv b_valid = mst b_valid & ~wr_empty[j], with j = mst b.id; mst b_ready = slv b_ready & ~wr_empty[j].
//   Handshake pops wr_fifo[j] and decrements wr_cnt.
// - R: same gating with rd_empty[j]. Pop and rd_cnt decrement only on a handshake with r.last=1.
// - Response whose FIFO is empty: stalls (ready 0), never forwarded with a stale ID.
// - Counter push+pop in the same cycle: count unchanged. Counter width holds NumMstIds*Max*Txns, no wrap.
// - FSM Idle:
//   - slv aw_valid with atop[5:4]!=ATOP_NONE: AW not forwarded.
//   - Go to Drain once no AR is pending (mst ar_valid=0) or the AR handshakes this cycle.
// - FSM Drain: AR and AW blocked (valid/ready 0). When rd_cnt==0 && wr_cnt==0:
//   - Forward the ATOP AW; handshake pushes wr_fifo[k].
//   - If atop[ATOP_R_RESP], the same handshake also pushes aw.id into rd_fifo[k].
//   - Go to Execute on the handshake.
// - FSM Execute: AR/AW blocked until both counters reach 0, counting pops in the current cycle.
//   - In that same cycle, return to Idle and apply the Idle gating combinationally (no bubble).
// - Reset mid-operation: FIFOs, counters and FSM clear immediately. In-flight downstream responses after reset
//   are stalled by the empty-FIFO rule.
// TESTING
// - Reads ID 4'h1 then 4'h5 (both fold to 1), R returned id 1 twice
//   -> upstream R ids 1 then 5 in order; rd_fifo[1] empty after both lasts.
// - Writes ID 4'h0 and 4'h3 in parallel, downstream B id 3 before id 0
//   -> upstream B id 3 then 0; no stall between them.
// - Fill rd_fifo[2] with 4 reads (ids 2,6,A,E), 5th read id 2
//   -> slv ar_ready=0 until an R last on id 2; a read with id 1 is accepted meanwhile.
// - ATOP AW (id 4'h7, atop R_RESP set) with 2 reads outstanding -> stays in Drain, AW held.
//   After the last R, AW issued with id 3. B and R return upstream id 7. New AR is accepted in the cycle the
//   last ATOP response pops.
// - Downstream B with id 2 while wr_fifo[2] empty -> mst b_ready=0, slv b_valid=0 indefinitely.
// - Assert rst_ni low with 3 writes outstanding -> after reset all empty; late B is not forwarded.

Source files
------------

// File: rtl/axi_id_fold_serializer.sv
// AXI ID fold serializer.
// Folds the upstream ID space onto 2**MstIdWidth downstream IDs. Ordering is kept per folded ID,
// and different folded IDs may still run in parallel. Per-folded-ID FIFOs remember the full upstream
// ID so that R/B can be restored. ATOPs are serialised globally: everything drains, the ATOP runs
// alone, and normal traffic resumes once the ATOP has completed.
// Port bundles are flat vectors. Field order is MSB first:
//   slv_req_i  : aw_valid, aw_id, aw_atop, aw_payload, w_valid, w_payload, b_ready,
//                ar_valid, ar_id, ar_payload, r_ready
//   slv_resp_o : aw_ready, w_ready, b_valid, b_id, b_payload, ar_ready, r_valid, r_id, r_payload, r_last
//   mst_req_o / mst_resp_i : the same layouts, with MstIdWidth-wide IDs.

// Non-fall-through ID FIFO. The head is valid whenever empty is low.
module axi_id_fold_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] data,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;

    assign full  = (count == CntWidth'(Depth));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset because an entry is only read after it has been written
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data;
    end
endmodule

module axi_id_fold_serializer #(
    parameter int unsigned MaxReadTxns    = 4,
    parameter int unsigned MaxWriteTxns   = 4,
    parameter int unsigned SlvIdWidth     = 4,
    parameter int unsigned MstIdWidth     = 2,
    parameter int unsigned AxPayloadWidth = 16,
    parameter int unsigned WPayloadWidth  = 9,
    parameter int unsigned BPayloadWidth  = 2,
    parameter int unsigned RPayloadWidth  = 10,
    localparam int unsigned SlvReqWidth   = 2*SlvIdWidth + 2*AxPayloadWidth + WPayloadWidth + 11,
    localparam int unsigned MstReqWidth   = 2*MstIdWidth + 2*AxPayloadWidth + WPayloadWidth + 11,
    localparam int unsigned SlvRespWidth  = 2*SlvIdWidth + BPayloadWidth + RPayloadWidth + 6,
    localparam int unsigned MstRespWidth  = 2*MstIdWidth + BPayloadWidth + RPayloadWidth + 6
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [SlvReqWidth-1:0]  slv_req_i,
    output logic [SlvRespWidth-1:0] slv_resp_o,
    output logic [MstReqWidth-1:0]  mst_req_o,
    input  logic [MstRespWidth-1:0] mst_resp_i
);
    localparam int unsigned NumMstIds  = 2**MstIdWidth;
    localparam int unsigned RdCntWidth = $clog2(NumMstIds*MaxReadTxns + 1);
    localparam int unsigned WrCntWidth = $clog2(NumMstIds*MaxWriteTxns + 1);
    localparam int unsigned AtopRResp  = 5;

    typedef enum logic [1:0] {Idle, Drain, Execute} state_e;

    // Upstream request fields
    logic                      slv_aw_valid, slv_w_valid, slv_b_ready, slv_ar_valid, slv_r_ready;
    logic [SlvIdWidth-1:0]     slv_aw_id, slv_ar_id;
    logic [5:0]                slv_aw_atop;
    logic [AxPayloadWidth-1:0] slv_aw_payload, slv_ar_payload;
    logic [WPayloadWidth-1:0]  slv_w_payload;
    // Downstream response fields
    logic                      mst_aw_ready, mst_w_ready, mst_b_valid, mst_ar_ready, mst_r_valid, mst_r_last;
    logic [MstIdWidth-1:0]     mst_b_id, mst_r_id;
    logic [BPayloadWidth-1:0]  mst_b_payload;
    logic [RPayloadWidth-1:0]  mst_r_payload;
    // Gated handshake signals
    logic                      mst_aw_valid, slv_aw_ready, mst_ar_valid, slv_ar_ready;
    logic                      slv_b_valid, mst_b_ready, slv_r_valid, mst_r_ready;
    logic [SlvIdWidth-1:0]     slv_b_id, slv_r_id;

    assign {slv_aw_valid, slv_aw_id, slv_aw_atop, slv_aw_payload, slv_w_valid, slv_w_payload, slv_b_ready,
            slv_ar_valid, slv_ar_id, slv_ar_payload, slv_r_ready} = slv_req_i;
    assign {mst_aw_ready, mst_w_ready, mst_b_valid, mst_b_id, mst_b_payload, mst_ar_ready,
            mst_r_valid, mst_r_id, mst_r_payload, mst_r_last} = mst_resp_i;
    assign mst_req_o = {mst_aw_valid, slv_aw_id[MstIdWidth-1:0], slv_aw_atop, slv_aw_payload,
                        slv_w_valid, slv_w_payload, mst_b_ready,
                        mst_ar_valid, slv_ar_id[MstIdWidth-1:0], slv_ar_payload, mst_r_ready};
    assign slv_resp_o = {slv_aw_ready, mst_w_ready, slv_b_valid, slv_b_id, mst_b_payload, slv_ar_ready,
                         slv_r_valid, slv_r_id, mst_r_payload, mst_r_last};

    state_e                  state_q, state_d;
    logic [RdCntWidth-1:0]   rd_cnt_q;
    logic [WrCntWidth-1:0]   wr_cnt_q;
    logic [NumMstIds-1:0]    rd_full, rd_empty, wr_full, wr_empty;
    logic [NumMstIds-1:0]    rd_push_vec, rd_pop_vec, wr_push_vec, wr_pop_vec;
    logic [SlvIdWidth-1:0]   rd_head [NumMstIds];
    logic [SlvIdWidth-1:0]   wr_head [NumMstIds];
    logic [SlvIdWidth-1:0]   rd_push_id;
    logic [MstIdWidth-1:0]   ar_k, aw_k, rd_push_idx;
    logic                    aw_is_atop, ar_push, aw_push, atop_r_push, rd_push_any;
    logic                    rd_pop_any, wr_pop_any, drained_now, idle_gate;

    assign ar_k       = slv_ar_id[MstIdWidth-1:0];
    assign aw_k       = slv_aw_id[MstIdWidth-1:0];
    assign aw_is_atop = (slv_aw_atop[5:4] != 2'b00);

    // Responses are only forwarded when an upstream ID is waiting for them; otherwise they stall
    assign slv_b_id    = wr_head[mst_b_id];
    assign slv_b_valid = mst_b_valid & ~wr_empty[mst_b_id];
    assign mst_b_ready = slv_b_ready & ~wr_empty[mst_b_id];
    assign slv_r_id    = rd_head[mst_r_id];
    assign slv_r_valid = mst_r_valid & ~rd_empty[mst_r_id];
    assign mst_r_ready = slv_r_ready & ~rd_empty[mst_r_id];

    assign wr_pop_any  = mst_b_valid & mst_b_ready;
    assign rd_pop_any  = mst_r_valid & mst_r_ready & mst_r_last;
    assign drained_now = ((rd_cnt_q - RdCntWidth'(rd_pop_any)) == '0) &&
                         ((wr_cnt_q - WrCntWidth'(wr_pop_any)) == '0);
    assign idle_gate   = (state_q == Idle) || ((state_q == Execute) && drained_now);

    // Request gating and FSM next state; the final Execute cycle already applies the Idle gating
    always_comb begin
        state_d      = state_q;
        mst_ar_valid = 1'b0;
        slv_ar_ready = 1'b0;
        mst_aw_valid = 1'b0;
        slv_aw_ready = 1'b0;
        ar_push      = 1'b0;
        aw_push      = 1'b0;
        atop_r_push  = 1'b0;
        case (state_q)
            Idle: ;
            Drain: begin
                if (rd_cnt_q == '0 && wr_cnt_q == '0) begin
                    mst_aw_valid = slv_aw_valid;
                    slv_aw_ready = mst_aw_ready;
                    if (slv_aw_valid && mst_aw_ready) begin
                        aw_push     = 1'b1;
                        atop_r_push = slv_aw_atop[AtopRResp];
                        state_d     = Execute;
                    end
                end
            end
            Execute: begin
                if (drained_now) state_d = Idle;
            end
            default: state_d = Idle;
        endcase
        if (idle_gate) begin
            mst_ar_valid = slv_ar_valid & ~rd_full[ar_k];
            slv_ar_ready = mst_ar_ready & ~rd_full[ar_k];
            ar_push      = mst_ar_valid & mst_ar_ready;
            if (aw_is_atop) begin
                if (slv_aw_valid && (!mst_ar_valid || ar_push)) state_d = Drain;
            end else begin
                mst_aw_valid = slv_aw_valid & ~wr_full[aw_k];
                slv_aw_ready = mst_aw_ready & ~wr_full[aw_k];
                aw_push      = mst_aw_valid & mst_aw_ready;
            end
        end
    end

    assign rd_push_any = ar_push | atop_r_push;
    assign rd_push_idx = ar_push ? ar_k : aw_k;
    assign rd_push_id  = ar_push ? slv_ar_id : slv_aw_id;

    // Decode pushes and pops onto the per-folded-ID FIFOs
    always_comb begin
        rd_push_vec = '0;
        rd_pop_vec  = '0;
        wr_push_vec = '0;
        wr_pop_vec  = '0;
        if (rd_push_any) rd_push_vec[rd_push_idx] = 1'b1;
        if (rd_pop_any)  rd_pop_vec[mst_r_id]     = 1'b1;
        if (aw_push)     wr_push_vec[aw_k]        = 1'b1;
        if (wr_pop_any)  wr_pop_vec[mst_b_id]     = 1'b1;
    end

    for (genvar g = 0; g < NumMstIds; g++) begin : gen_fifos
        axi_id_fold_fifo #(.Depth(MaxReadTxns), .Width(SlvIdWidth)) i_rd_fifo (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .push  (rd_push_vec[g]),
            .pop   (rd_pop_vec[g]),
            .data  (rd_push_id),
            .head  (rd_head[g]),
            .full  (rd_full[g]),
            .empty (rd_empty[g])
        );
        axi_id_fold_fifo #(.Depth(MaxWriteTxns), .Width(SlvIdWidth)) i_wr_fifo (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .push  (wr_push_vec[g]),
            .pop   (wr_pop_vec[g]),
            .data  (slv_aw_id),
            .head  (wr_head[g]),
            .full  (wr_full[g]),
            .empty (wr_empty[g])
        );
    end

    // FSM state and outstanding-transaction counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= Idle;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_q + RdCntWidth'(rd_push_any) - RdCntWidth'(rd_pop_any);
            wr_cnt_q <= wr_cnt_q + WrCntWidth'(aw_push) - WrCntWidth'(wr_pop_any);
        end
    end
endmodule

// File: tb/tb_axi_id_fold_serializer.sv
// Testbench for axi_id_fold_serializer: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model of the folding and ATOP serialisation rules.
module tb_axi_id_fold_serializer;
    localparam int MaxR = 4;
    localparam int MaxW = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    // Upstream request (driven)
    logic        slv_aw_valid, slv_w_valid, slv_b_ready, slv_ar_valid, slv_r_ready;
    logic [3:0]  slv_aw_id, slv_ar_id;
    logic [5:0]  slv_aw_atop;
    logic [15:0] slv_aw_pay, slv_ar_pay;
    logic [8:0]  slv_w_pay;
    // Downstream response (driven)
    logic        mst_aw_ready, mst_w_ready, mst_b_valid, mst_ar_ready, mst_r_valid, mst_r_last;
    logic [1:0]  mst_b_id, mst_r_id;
    logic [1:0]  mst_b_pay;
    logic [9:0]  mst_r_pay;
    // Upstream response (observed)
    logic        slv_aw_ready, slv_w_ready, slv_b_valid, slv_ar_ready, slv_r_valid, slv_r_last;
    logic [3:0]  slv_b_id, slv_r_id;
    logic [1:0]  slv_b_pay;
    logic [9:0]  slv_r_pay;
    // Downstream request (observed)
    logic        mst_aw_valid, mst_w_valid, mst_b_ready, mst_ar_valid, mst_r_ready;
    logic [1:0]  mst_aw_id, mst_ar_id;
    logic [5:0]  mst_aw_atop;
    logic [15:0] mst_aw_pay, mst_ar_pay;
    logic [8:0]  mst_w_pay;

    logic [59:0] slv_req;
    logic [25:0] slv_resp;
    logic [55:0] mst_req;
    logic [21:0] mst_resp;

    assign slv_req  = {slv_aw_valid, slv_aw_id, slv_aw_atop, slv_aw_pay, slv_w_valid, slv_w_pay, slv_b_ready,
                       slv_ar_valid, slv_ar_id, slv_ar_pay, slv_r_ready};
    assign mst_resp = {mst_aw_ready, mst_w_ready, mst_b_valid, mst_b_id, mst_b_pay, mst_ar_ready,
                       mst_r_valid, mst_r_id, mst_r_pay, mst_r_last};
    assign {slv_aw_ready, slv_w_ready, slv_b_valid, slv_b_id, slv_b_pay, slv_ar_ready,
            slv_r_valid, slv_r_id, slv_r_pay, slv_r_last} = slv_resp;
    assign {mst_aw_valid, mst_aw_id, mst_aw_atop, mst_aw_pay, mst_w_valid, mst_w_pay, mst_b_ready,
            mst_ar_valid, mst_ar_id, mst_ar_pay, mst_r_ready} = mst_req;

    axi_id_fold_serializer dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .slv_req_i (slv_req),
        .slv_resp_o(slv_resp),
        .mst_req_o (mst_req),
        .mst_resp_i(mst_resp)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: upstream IDs waiting per folded ID, and the ATOP phase
    typedef enum int {M_IDLE, M_DRAIN, M_EXEC} mode_e;
    mode_e      mode = M_IDLE;
    logic [3:0] rd_q [4][$];
    logic [3:0] wr_q [4][$];

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 4; i++) begin
            rd_q[i].delete();
            wr_q[i].delete();
        end
        mode = M_IDLE;
    endtask

    task automatic quietInputs();
        slv_aw_valid = 0; slv_aw_id = 0; slv_aw_atop = 0; slv_aw_pay = 16'($urandom);
        slv_w_valid  = 0; slv_w_pay = 9'($urandom); slv_b_ready = 1;
        slv_ar_valid = 0; slv_ar_id = 0; slv_ar_pay = 16'($urandom); slv_r_ready = 1;
        mst_aw_ready = 1; mst_w_ready = 1; mst_b_valid = 0; mst_b_id = 0; mst_b_pay = 2'($urandom);
        mst_ar_ready = 1; mst_r_valid = 0; mst_r_id = 0; mst_r_pay = 10'($urandom); mst_r_last = 0;
    endtask

    // Evaluate the model for the inputs currently applied, compare, then advance the model
    task automatic applyStimulus();
        int  rd_total, wr_total, bj, rj, ka, kw;
        bit  b_ok, r_ok, b_pop, r_pop, gate, aw_fwd, is_atop, ar_room, aw_room;
        bit  e_ar_valid, e_ar_ready, e_aw_valid, e_aw_ready, ar_hs, aw_hs;
        #1;
        rd_total = 0;
        wr_total = 0;
        for (int i = 0; i < 4; i++) begin
            rd_total += rd_q[i].size();
            wr_total += wr_q[i].size();
        end
        bj = int'(mst_b_id);
        rj = int'(mst_r_id);
        ka = int'(slv_ar_id[1:0]);
        kw = int'(slv_aw_id[1:0]);
        b_ok = wr_q[bj].size() != 0;
        r_ok = rd_q[rj].size() != 0;
        checkOutput("b_valid", slv_b_valid, mst_b_valid & b_ok);
        checkOutput("b_ready", mst_b_ready, slv_b_ready & b_ok);
        if (mst_b_valid && b_ok) checkOutput("b_id", slv_b_id, wr_q[bj][0]);
        checkOutput("r_valid", slv_r_valid, mst_r_valid & r_ok);
        checkOutput("r_ready", mst_r_ready, slv_r_ready & r_ok);
        if (mst_r_valid && r_ok) checkOutput("r_id", slv_r_id, rd_q[rj][0]);
        b_pop   = mst_b_valid & slv_b_ready & b_ok;
        r_pop   = mst_r_valid & slv_r_ready & r_ok & mst_r_last;
        gate    = (mode == M_IDLE) || (mode == M_EXEC && rd_total - int'(r_pop) == 0 && wr_total - int'(b_pop) == 0);
        aw_fwd  = (mode == M_DRAIN) && rd_total == 0 && wr_total == 0;
        is_atop = slv_aw_atop[5:4] != 2'b00;
        ar_room = rd_q[ka].size() < MaxR;
        aw_room = wr_q[kw].size() < MaxW;
        e_ar_valid = gate & slv_ar_valid & ar_room;
        e_ar_ready = gate & mst_ar_ready & ar_room;
        e_aw_valid = gate ? (slv_aw_valid & !is_atop & aw_room) : (aw_fwd & slv_aw_valid);
        e_aw_ready = gate ? (mst_aw_ready & !is_atop & aw_room) : (aw_fwd & mst_aw_ready);
        checkOutput("ar_valid", mst_ar_valid, e_ar_valid);
        checkOutput("ar_ready", slv_ar_ready, e_ar_ready);
        checkOutput("aw_valid", mst_aw_valid, e_aw_valid);
        checkOutput("aw_ready", slv_aw_ready, e_aw_ready);
        checkOutput("ar_fold_id", mst_ar_id, slv_ar_id[1:0]);
        checkOutput("aw_fold_id", mst_aw_id, slv_aw_id[1:0]);
        checkOutput("ax_pass", {mst_aw_atop, mst_aw_pay, mst_ar_pay}, {slv_aw_atop, slv_aw_pay, slv_ar_pay});
        checkOutput("w_pass", {mst_w_valid, mst_w_pay, slv_w_ready}, {slv_w_valid, slv_w_pay, mst_w_ready});
        checkOutput("rsp_pass", {slv_b_pay, slv_r_pay, slv_r_last}, {mst_b_pay, mst_r_pay, mst_r_last});
        if (!rst_ni) return;
        ar_hs = e_ar_valid & mst_ar_ready;
        aw_hs = e_aw_valid & mst_aw_ready;
        if (b_pop) void'(wr_q[bj].pop_front());
        if (r_pop) void'(rd_q[rj].pop_front());
        if (ar_hs) rd_q[ka].push_back(slv_ar_id);
        if (aw_hs) wr_q[kw].push_back(slv_aw_id);
        if (gate) begin
            mode = M_IDLE;
            if (slv_aw_valid && is_atop && (!e_ar_valid || ar_hs)) mode = M_DRAIN;
        end else if (aw_fwd && aw_hs) begin
            if (slv_aw_atop[5]) rd_q[kw].push_back(slv_aw_id);
            mode = M_EXEC;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycle();
        applyStimulus();
        tick();
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        clearModel();
        quietInputs();
        cycle();
        cycle();
        rst_ni = 1'b1;
    endtask

    task automatic randomStimulus();
        if (mode != M_DRAIN) begin
            slv_aw_valid = 1'($urandom_range(0, 1));
            slv_aw_id    = 4'($urandom);
            slv_aw_atop  = ($urandom_range(0, 9) == 0) ? {2'($urandom_range(1, 3)), 4'($urandom)} : 6'h00;
            slv_aw_pay   = 16'($urandom);
        end
        slv_w_valid  = 1'($urandom_range(0, 1)); slv_w_pay  = 9'($urandom);
        slv_b_ready  = 1'($urandom_range(0, 3) != 0);
        slv_ar_valid = 1'($urandom_range(0, 1)); slv_ar_id  = 4'($urandom); slv_ar_pay = 16'($urandom);
        slv_r_ready  = 1'($urandom_range(0, 3) != 0);
        mst_aw_ready = 1'($urandom_range(0, 1)); mst_w_ready = 1'($urandom_range(0, 1));
        mst_ar_ready = 1'($urandom_range(0, 1));
        mst_b_valid  = 1'($urandom_range(0, 1)); mst_b_id = 2'($urandom); mst_b_pay = 2'($urandom);
        mst_r_valid  = 1'($urandom_range(0, 1)); mst_r_id = 2'($urandom); mst_r_pay = 10'($urandom);
        mst_r_last   = 1'($urandom_range(0, 1));
    endtask

    initial begin
        quietInputs();
        doReset();

        $display("[TB] reads 1 and 5 share folded ID 1");
        slv_ar_valid = 1; slv_ar_id = 4'h1; cycle();
        slv_ar_id = 4'h5; cycle();
        slv_ar_valid = 0; mst_r_valid = 1; mst_r_id = 2'd1; mst_r_last = 1;
        applyStimulus(); checkOutput("s1_r_first", slv_r_id, 4'h1); tick();
        applyStimulus(); checkOutput("s1_r_second", slv_r_id, 4'h5); tick();
        applyStimulus(); checkOutput("s1_r_empty", {slv_r_valid, mst_r_ready}, 2'b00); tick();
        quietInputs();

        $display("[TB] writes 0 and 3 complete out of order");
        doReset();
        slv_aw_valid = 1; slv_aw_id = 4'h0; cycle();
        slv_aw_id = 4'h3; cycle();
        slv_aw_valid = 0; mst_b_valid = 1; mst_b_id = 2'd3;
        applyStimulus(); checkOutput("s2_b_first", {slv_b_valid, slv_b_id}, {1'b1, 4'h3}); tick();
        mst_b_id = 2'd0;
        applyStimulus(); checkOutput("s2_b_second", {slv_b_valid, slv_b_id}, {1'b1, 4'h0}); tick();
        quietInputs();

        $display("[TB] folded read ID 2 fills up");
        doReset();
        slv_ar_valid = 1;
        slv_ar_id = 4'h2; cycle();
        slv_ar_id = 4'h6; cycle();
        slv_ar_id = 4'hA; cycle();
        slv_ar_id = 4'hE; cycle();
        slv_ar_id = 4'h2;
        applyStimulus(); checkOutput("s3_full_block", {slv_ar_ready, mst_ar_valid}, 2'b00); tick();
        slv_ar_id = 4'h1;
        applyStimulus(); checkOutput("s3_other_id", slv_ar_ready, 1'b1); tick();
        slv_ar_id = 4'h2; mst_r_valid = 1; mst_r_id = 2'd2; mst_r_last = 1;
        applyStimulus(); checkOutput("s3_still_full", slv_ar_ready, 1'b0); tick();
        mst_r_valid = 0;
        applyStimulus(); checkOutput("s3_room_again", slv_ar_ready, 1'b1); tick();
        quietInputs();

        $display("[TB] ATOP waits for outstanding reads");
        doReset();
        slv_ar_valid = 1; slv_ar_id = 4'h0; cycle();
        slv_ar_id = 4'h1; cycle();
        slv_ar_valid = 0; slv_aw_valid = 1; slv_aw_id = 4'h7; slv_aw_atop = 6'h20;
        applyStimulus(); checkOutput("s4_atop_held_idle", mst_aw_valid, 1'b0); tick();
        applyStimulus(); checkOutput("s4_atop_held_drain", {mst_aw_valid, slv_aw_ready}, 2'b00); tick();
        mst_r_valid = 1; mst_r_last = 1; mst_r_id = 2'd0; cycle();
        mst_r_id = 2'd1;
        applyStimulus(); checkOutput("s4_atop_still_held", mst_aw_valid, 1'b0); tick();
        mst_r_valid = 0;
        applyStimulus(); checkOutput("s4_atop_issued", {mst_aw_valid, mst_aw_id}, {1'b1, 2'd3}); tick();
        slv_aw_valid = 0; slv_aw_atop = 0; slv_aw_id = 0;
        slv_ar_valid = 1; slv_ar_id = 4'h2; mst_b_valid = 1; mst_b_id = 2'd3;
        applyStimulus(); checkOutput("s4_b_restored", {slv_b_valid, slv_b_id, slv_ar_ready}, {1'b1, 4'h7, 1'b0}); tick();
        mst_b_valid = 0; mst_r_valid = 1; mst_r_id = 2'd3; mst_r_last = 1;
        applyStimulus(); checkOutput("s4_r_restored_ar_open", {slv_r_valid, slv_r_id, slv_ar_ready}, {1'b1, 4'h7, 1'b1}); tick();
        quietInputs();

        $display("[TB] stray downstream B is stalled");
        doReset();
        mst_b_valid = 1; mst_b_id = 2'd2;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(); checkOutput("s5_stray_b", {slv_b_valid, mst_b_ready}, 2'b00); tick();
        end
        quietInputs();

        $display("[TB] reset with writes outstanding");
        slv_aw_valid = 1;
        for (int i = 0; i < 3; i++) begin
            slv_aw_id = 4'(i); cycle();
        end
        doReset();
        mst_b_valid = 1; mst_b_id = 2'd0;
        applyStimulus(); checkOutput("s6_late_b", {slv_b_valid, mst_b_ready}, 2'b00); tick();
        quietInputs();

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            randomStimulus();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
